// File: rtl/seven_hex.sv
// Dual-digit hex 7-segment decoder with registered outputs (ABCDEFG, 1-cycle latency).
// Optional leading-zero blanking of digit a when SEVEN_HEX_BLANK_EN is defined.
module seven_hex #(
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] I,
    output logic       A_a,
    output logic       B_a,
    output logic       C_a,
    output logic       D_a,
    output logic       E_a,
    output logic       F_a,
    output logic       G_a,
    output logic       A_b,
    output logic       B_b,
    output logic       C_b,
    output logic       D_b,
    output logic       E_b,
    output logic       F_b,
    output logic       G_b
);

    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        logic [6:0] seg;
        seg = '0;
        case (n)
            4'h0: seg = 7'b1111110;
            4'h1: seg = 7'b0110000;
            4'h2: seg = 7'b1101101;
            4'h3: seg = 7'b1111001;
            4'h4: seg = 7'b0110011;
            4'h5: seg = 7'b1011011;
            4'h6: seg = 7'b1011111;
            4'h7: seg = 7'b1110000;
            4'h8: seg = 7'b1111111;
            4'h9: seg = 7'b1111011;
            4'hA: seg = 7'b1110111;
            4'hB: seg = 7'b0011111;
            4'hC: seg = 7'b1001110;
            4'hD: seg = 7'b0111101;
            4'hE: seg = 7'b1001111;
            4'hF: seg = 7'b1000111;
            default: seg = '0;
        endcase
        return seg;
    endfunction

    // Polarity is folded in before the register so outputs come straight from flops.
    logic [6:0] pol;
    logic [6:0] lit_a;
    logic [6:0] lit_b;
    logic [6:0] next_a;
    logic [6:0] next_b;
    logic [6:0] seg_a;
    logic [6:0] seg_b;

    assign pol = {7{SEG_ACTIVE_LOW}};

    always_comb begin
        lit_a = hex_to_seg(I[7:4]);
        lit_b = hex_to_seg(I[3:0]);
`ifdef SEVEN_HEX_BLANK_EN
        if (I[7:4] == 4'h0) begin
            lit_a = '0;
        end
`endif
        next_a = lit_a ^ pol;
        next_b = lit_b ^ pol;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seg_a <= pol;
            seg_b <= pol;
        end else begin
            seg_a <= next_a;
            seg_b <= next_b;
        end
    end

    assign {A_a, B_a, C_a, D_a, E_a, F_a, G_a} = seg_a;
    assign {A_b, B_b, C_b, D_b, E_b, F_b, G_b} = seg_b;

endmodule

// File: tb/tb_seven_hex.sv
// Directed bench for seven_hex: one active-high and one active-low instance driven by the same I.
module tb_seven_hex;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] I = 8'h00;

    logic A_a0, B_a0, C_a0, D_a0, E_a0, F_a0, G_a0;
    logic A_b0, B_b0, C_b0, D_b0, E_b0, F_b0, G_b0;
    logic A_a1, B_a1, C_a1, D_a1, E_a1, F_a1, G_a1;
    logic A_b1, B_b1, C_b1, D_b1, E_b1, F_b1, G_b1;

    int compared = 0;
    int mismatched = 0;

`ifdef SEVEN_HEX_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    // ABCDEFG patterns for 0..F, lit = 1
    localparam logic [6:0] TAB [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    seven_hex #(.SEG_ACTIVE_LOW(1'b0)) dut_hi (
        .clk(clk), .reset(reset), .I(I),
        .A_a(A_a0), .B_a(B_a0), .C_a(C_a0), .D_a(D_a0), .E_a(E_a0), .F_a(F_a0), .G_a(G_a0),
        .A_b(A_b0), .B_b(B_b0), .C_b(C_b0), .D_b(D_b0), .E_b(E_b0), .F_b(F_b0), .G_b(G_b0)
    );

    seven_hex #(.SEG_ACTIVE_LOW(1'b1)) dut_lo (
        .clk(clk), .reset(reset), .I(I),
        .A_a(A_a1), .B_a(B_a1), .C_a(C_a1), .D_a(D_a1), .E_a(E_a1), .F_a(F_a1), .G_a(G_a1),
        .A_b(A_b1), .B_b(B_b1), .C_b(C_b1), .D_b(D_b1), .E_b(E_b1), .F_b(F_b1), .G_b(G_b1)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] exp_a(input logic [7:0] v);
        logic [6:0] p;
        p = TAB[v[7:4]];
        if (BLANK && v[7:4] == 4'h0) p = 7'b0000000;
        return p;
    endfunction

    function automatic logic [6:0] exp_b(input logic [7:0] v);
        return TAB[v[3:0]];
    endfunction

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag, input logic [6:0] ea, input logic [6:0] eb);
        check({tag, " a hi"}, {A_a0, B_a0, C_a0, D_a0, E_a0, F_a0, G_a0}, ea);
        check({tag, " b hi"}, {A_b0, B_b0, C_b0, D_b0, E_b0, F_b0, G_b0}, eb);
        check({tag, " a lo"}, {A_a1, B_a1, C_a1, D_a1, E_a1, F_a1, G_a1}, ~ea);
        check({tag, " b lo"}, {A_b1, B_b1, C_b1, D_b1, E_b1, F_b1, G_b1}, ~eb);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held for two edges with I=0: everything unlit
        reset = 1'b1; I = 8'h00;
        step();
        check_all("reset1", 7'b0000000, 7'b0000000);
        step();
        check_all("reset2", 7'b0000000, 7'b0000000);

        // Reset overrides a non-zero I
        I = 8'h88;
        step();
        check_all("reset_override", 7'b0000000, 7'b0000000);

        // First edge out of reset loads the current I
        reset = 1'b0; I = 8'h00;
        step();
        check_all("release_00", BLANK ? 7'b0000000 : 7'b1111110, 7'b1111110);

        I = 8'h01;
        step();
        check_all("v01", BLANK ? 7'b0000000 : 7'b1111110, 7'b0110000);

        I = 8'h06;
        step();
        check_all("v06", BLANK ? 7'b0000000 : 7'b1111110, 7'b1011111);

        I = 8'h7F;
        step();
        check_all("v7F", 7'b1110000, 7'b1000111);

        I = 8'h0A;
        step();
        check_all("v0A", BLANK ? 7'b0000000 : 7'b1111110, 7'b1110111);

        I = 8'hBD;
        step();
        check_all("vBD", 7'b0011111, 7'b0111101);

        // Full sweep, one value per cycle, with a one-cycle reset pulse at 0x80
        for (int v = 0; v < 256; v++) begin
            I = 8'(v);
            if (v == 8'h80) begin
                reset = 1'b1;
                step();
                check_all("sweep_reset", 7'b0000000, 7'b0000000);
                reset = 1'b0;
            end
            step();
            check_all($sformatf("sweep_%02h", v), exp_a(8'(v)), exp_b(8'(v)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, expected finish within 100000 time units");
        $fatal(1, "timeout");
    end

endmodule
